// File: rtl/nios2_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks.
//   - Register word offsets of the Avalon-MM slave.
//   - Edge-type selector constants for the capture logic.
//   - edge_detect(): single-bit edge qualifier used by the capture logic.
package nios2_system_pio_pkg;

    // Avalon-MM word offsets
    localparam logic [1:0] DATA        = 2'd0;
    localparam logic [1:0] DIRECTION   = 2'd1;
    localparam logic [1:0] IRQMASK     = 2'd2;
    localparam logic [1:0] EDGECAPTURE = 2'd3;

    // EDGE_TYPE encodings
    localparam int RISING  = 0;
    localparam int FALLING = 1;
    localparam int ANY     = 2;

    // Returns 1 when the transition prev -> cur qualifies for the given edge type.
    function automatic logic edge_detect(input logic prev, input logic cur, input int edge_type);
        case (edge_type)
            RISING:  return ~prev & cur;
            FALLING: return prev & ~cur;
            default: return prev ^ cur;
        endcase
    endfunction

endpackage

// File: rtl/nios2_system_key_pio_if.sv
// Avalon-MM slave bus bundle for the key PIO.
//   address    : word address (master -> slave)
//   chipselect : slave select (master -> slave)
//   write_n    : active-low write strobe (master -> slave)
//   writedata  : write data (master -> slave)
//   readdata   : registered read data, latency 1 (slave -> master)
interface nios2_system_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_system_pio_debounce.sv
// One-bit input conditioner: SYNC_STAGES-deep synchronizer followed by a
// saturating stability counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_i         : raw asynchronous input bit
//   db_o         : synchronized, debounced bit
// The debounced bit takes the synchronized value once the two have disagreed
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module nios2_system_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic db_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign db_o = s;
    end else begin : g_debounce
        localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q,  db_d;

        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (s == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
                db_d  = s;
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                db_q  <= IDLE_LEVEL;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign db_o = db_q;
    end

endmodule

// File: rtl/nios2_system_key_pio.sv
// Key/switch PIO with edge capture and level interrupt, Avalon-MM slave.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port      : asynchronous key/switch inputs
//   irq          : OR of (edgecapture & irqmask)
// Register map: 0 data (RO), 1 direction (reads 0), 2 irqmask (RW), 3 edgecapture (RW1C).
module nios2_system_key_pio
    import nios2_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_system_key_pio_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios2_system_pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (in_port[i]),
            .db_o    (d[i])
        );
    end

    // Write data above WIDTH-1 is architecturally ignored.
    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^bus.writedata[31:WIDTH];
    end

    always_comb begin
        wr_en      = bus.chipselect & ~bus.write_n;
        irqmask_d  = irqmask_q;
        clear_mask = '0;
        readdata_d = '0;

        if (wr_en && bus.address == IRQMASK)     irqmask_d  = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == EDGECAPTURE) clear_mask = bus.writedata[WIDTH-1:0];

        for (int i = 0; i < WIDTH; i++) begin
            edge_det[i] = edge_detect(d_prev_q[i], d[i], EDGE_TYPE);
        end

        // Clear first, then OR in new edges: a coincident edge wins.
        edgecap_d = (edgecap_q & ~clear_mask) | edge_det;

        case (bus.address)
            DATA:        readdata_d[WIDTH-1:0] = d;
            IRQMASK:     readdata_d[WIDTH-1:0] = irqmask_q;
            EDGECAPTURE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:     readdata_d = '0;   // DIRECTION reads as all-input
        endcase
    end

    // d_prev resets to the idle level so an idle input after reset shows no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev_q   <= {WIDTH{IDLE_LEVEL}};
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            d_prev_q   <= d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    // Pure AND/OR of flop outputs: no combinational path from inputs.
    assign irq = |(edgecap_q & irqmask_q);

endmodule
